// File: rtl/bit_collector_3ch_if.sv
// Output word stream of the bit collector: head-of-FIFO word plus channel tag, valid/ready.
interface bit_collector_3ch_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_ch;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/bit_collector_3ch.sv
// Deserializes a channel-tagged serial bit stream into WIDTH-bit words per channel (3 channels).
// Completed word is visible one cycle after its last bit; a 2-entry FIFO absorbs stalls, excess words are dropped.
module bit_collector_3ch #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic [1:0]          bit_ch,
  input  logic                flush,
  input  logic                clear_err,
  bit_collector_3ch_if.master out_bus,
  output logic [1:0]          level,
  output logic                overflow,
  output logic                bad_ch
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr  [3];
  logic [CW-1:0]    cnt [3];

  logic [WIDTH-1:0] e0_dat, e1_dat;
  logic [1:0]       e0_ch, e1_ch;

  logic             accept;
  logic             push;
  logic             pop;
  logic [1:0]       k;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    // Channel 3 is folded onto 0 only to keep the index in range; accept masks it out.
    k       = (bit_ch == 2'd3) ? 2'd0 : bit_ch;
    accept  = bit_valid & ~flush & (bit_ch != 2'd3);
    shifted = MSB_FIRST ? {sr[k][WIDTH-2:0], bit_in} : {bit_in, sr[k][WIDTH-1:1]};
    push    = accept & (cnt[k] == CW'(WIDTH-1));
    pop     = out_bus.out_valid & out_bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        sr[i]  <= '0;
        cnt[i] <= '0;
      end
      e0_dat   <= '0;
      e0_ch    <= '0;
      e1_dat   <= '0;
      e1_ch    <= '0;
      level    <= '0;
      overflow <= 1'b0;
      bad_ch   <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else if (accept) begin
        sr[k]  <= shifted;
        cnt[k] <= push ? '0 : cnt[k] + CW'(1);
      end

      // Head lives in entry 0; vacated entries are zeroed so an empty FIFO shows 0 on the bus.
      case (level)
        2'd0: begin
          if (push) begin
            e0_dat <= shifted;
            e0_ch  <= k;
            level  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0_dat <= shifted;
            e0_ch  <= k;
          end else if (push) begin
            e1_dat <= shifted;
            e1_ch  <= k;
            level  <= 2'd2;
          end else if (pop) begin
            e0_dat <= '0;
            e0_ch  <= '0;
            level  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            e0_dat <= e1_dat;
            e0_ch  <= e1_ch;
            if (push) begin
              e1_dat <= shifted;
              e1_ch  <= k;
            end else begin
              e1_dat <= '0;
              e1_ch  <= '0;
              level  <= 2'd1;
            end
          end
        end
      endcase

      if (push && (level == 2'd2) && !pop) overflow <= 1'b1;
      else if (clear_err)                  overflow <= 1'b0;

      if (bit_valid && (bit_ch == 2'd3)) bad_ch <= 1'b1;
      else if (clear_err)                bad_ch <= 1'b0;
    end
  end

  assign out_bus.out_data  = e0_dat;
  assign out_bus.out_ch    = e0_ch;
  assign out_bus.out_valid = (level != 2'd0);

endmodule
